// File: rtl/xsecure_lfsr_ctrl_pkg.sv
// Shared configuration types, default constants and the Galois step helper
// for the security LFSR controller.
package xsecure_lfsr_ctrl_pkg;

    typedef struct packed {
        logic [31:0] seed;
        logic [31:0] taps;
    } lfsr_cfg_t;

    localparam logic [31:0] LFSR0_SEED_DEFAULT = 32'hACE1_3579;
    localparam logic [31:0] LFSR1_SEED_DEFAULT = 32'h5A5A_C3E7;
    localparam logic [31:0] LFSR2_SEED_DEFAULT = 32'h1F2E_3D4C;
    localparam logic [31:0] LFSR_TAPS_DEFAULT  = 32'h8020_0003;

    localparam lfsr_cfg_t LFSR_CFG_DEFAULT = '{seed: LFSR0_SEED_DEFAULT, taps: LFSR_TAPS_DEFAULT};

    // One Galois step: shift right, fold the taps in when a one falls out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] q, input logic [31:0] taps);
        lfsr_step = {1'b0, q[31:1]} ^ (q[0] ? taps : 32'h0000_0000);
    endfunction

endpackage

// File: rtl/xsecure_lfsr_ctrl_unit.sv
// Single 32-bit Galois LFSR with seed load, advance and all-zero recovery.
// The unregistered lockup condition is exported so the parent can register its alert.
module xsecure_lfsr_unit
    import xsecure_lfsr_ctrl_pkg::*;
#(
    parameter lfsr_cfg_t CFG = LFSR_CFG_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_we,
    input  logic [31:0] seed_wdata,
    input  logic        shift,
    output logic [31:0] lfsr_q,
    output logic        lockup,
    output logic        lockup_cond
);

    logic [31:0] cand_s;
    logic        zero_s;
    logic [31:0] lfsr_r;
    logic        lockup_r;

    // Candidate next state: a seed write overrides a same-cycle shift.
    always_comb begin
        cand_s = lfsr_r;
        if (seed_we) begin
            cand_s = seed_wdata;
        end else if (shift) begin
            cand_s = lfsr_step(lfsr_r, CFG.taps);
        end else begin
            cand_s = lfsr_r;
        end
    end

    // Checked every cycle so a corrupted held zero also recovers.
    assign zero_s = (cand_s == 32'h0000_0000);

    // State and lockup pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_r   <= CFG.seed;
            lockup_r <= 1'b0;
        end else begin
            lfsr_r   <= zero_s ? CFG.seed : cand_s;
            lockup_r <= zero_s;
        end
    end

    assign lfsr_q      = lfsr_r;
    assign lockup      = lockup_r;
    assign lockup_cond = zero_s;

endmodule

// File: rtl/xsecure_lfsr_ctrl.sv
// Owns the three security LFSRs and produces the dummy-instruction counter
// reset pulse plus the minor alert raised on lockup recovery.
module xsecure_lfsr_ctrl
    import xsecure_lfsr_ctrl_pkg::*;
#(
    parameter logic [31:0] LFSR0_SEED = LFSR0_SEED_DEFAULT,
    parameter logic [31:0] LFSR1_SEED = LFSR1_SEED_DEFAULT,
    parameter logic [31:0] LFSR2_SEED = LFSR2_SEED_DEFAULT,
    parameter logic [31:0] LFSR_TAPS  = LFSR_TAPS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  seed_we_i,
    input  logic [31:0] seed_wdata_i,
    input  logic [2:0]  shift_i,
    input  logic        cpuctrl_we_i,
    output logic [31:0] lfsr0_o,
    output logic [31:0] lfsr1_o,
    output logic [31:0] lfsr2_o,
    output logic        cntrst_o,
    output logic [2:0]  lockup_o,
    output logic        alert_minor_o
);

    localparam lfsr_cfg_t LFSR0_CFG = '{seed: LFSR0_SEED, taps: LFSR_TAPS};
    localparam lfsr_cfg_t LFSR1_CFG = '{seed: LFSR1_SEED, taps: LFSR_TAPS};
    localparam lfsr_cfg_t LFSR2_CFG = '{seed: LFSR2_SEED, taps: LFSR_TAPS};

    logic [2:0] lockup_cond_s;
    logic       cntrst_r;
    logic       alert_minor_r;

    xsecure_lfsr_unit #(.CFG(LFSR0_CFG)) u_lfsr0 (
        .clk         (clk),
        .rst         (rst),
        .seed_we     (seed_we_i[0]),
        .seed_wdata  (seed_wdata_i),
        .shift       (shift_i[0]),
        .lfsr_q      (lfsr0_o),
        .lockup      (lockup_o[0]),
        .lockup_cond (lockup_cond_s[0])
    );

    xsecure_lfsr_unit #(.CFG(LFSR1_CFG)) u_lfsr1 (
        .clk         (clk),
        .rst         (rst),
        .seed_we     (seed_we_i[1]),
        .seed_wdata  (seed_wdata_i),
        .shift       (shift_i[1]),
        .lfsr_q      (lfsr1_o),
        .lockup      (lockup_o[1]),
        .lockup_cond (lockup_cond_s[1])
    );

    xsecure_lfsr_unit #(.CFG(LFSR2_CFG)) u_lfsr2 (
        .clk         (clk),
        .rst         (rst),
        .seed_we     (seed_we_i[2]),
        .seed_wdata  (seed_wdata_i),
        .shift       (shift_i[2]),
        .lfsr_q      (lfsr2_o),
        .lockup      (lockup_o[2]),
        .lockup_cond (lockup_cond_s[2])
    );

    // Counter-reset pulse and alert, registered so they align with lockup_o.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cntrst_r      <= 1'b0;
            alert_minor_r <= 1'b0;
        end else begin
            cntrst_r      <= seed_we_i[0] | cpuctrl_we_i;
            alert_minor_r <= |lockup_cond_s;
        end
    end

    assign cntrst_o      = cntrst_r;
    assign alert_minor_o = alert_minor_r;

endmodule

// File: tb/tb_xsecure_lfsr_ctrl.sv
// Directed bench for xsecure_lfsr_ctrl with hand-computed expected values.
module tb_xsecure_lfsr_ctrl;

    logic        clk;
    logic        rst;
    logic [2:0]  seed_we_i;
    logic [31:0] seed_wdata_i;
    logic [2:0]  shift_i;
    logic        cpuctrl_we_i;
    logic [31:0] lfsr0_o;
    logic [31:0] lfsr1_o;
    logic [31:0] lfsr2_o;
    logic        cntrst_o;
    logic [2:0]  lockup_o;
    logic        alert_minor_o;

    int checks;
    int errors;

    xsecure_lfsr_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .seed_we_i     (seed_we_i),
        .seed_wdata_i  (seed_wdata_i),
        .shift_i       (shift_i),
        .cpuctrl_we_i  (cpuctrl_we_i),
        .lfsr0_o       (lfsr0_o),
        .lfsr1_o       (lfsr1_o),
        .lfsr2_o       (lfsr2_o),
        .cntrst_o      (cntrst_o),
        .lockup_o      (lockup_o),
        .alert_minor_o (alert_minor_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] l0, input logic [31:0] l1,
                           input logic [31:0] l2, input logic cr, input logic [2:0] lk,
                           input logic al);
        chk({tag, "_lfsr0"}, lfsr0_o, l0);
        chk({tag, "_lfsr1"}, lfsr1_o, l1);
        chk({tag, "_lfsr2"}, lfsr2_o, l2);
        chk({tag, "_cntrst"}, {31'd0, cntrst_o}, {31'd0, cr});
        chk({tag, "_lockup"}, {29'd0, lockup_o}, {29'd0, lk});
        chk({tag, "_alert"}, {31'd0, alert_minor_o}, {31'd0, al});
    endtask

    task automatic idle();
        seed_we_i    = 3'b000;
        seed_wdata_i = 32'h0000_0000;
        shift_i      = 3'b000;
        cpuctrl_we_i = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        idle();
        #2;
        chk_all("in_reset", 32'hACE1_3579, 32'h5A5A_C3E7, 32'h1F2E_3D4C, 1'b0, 3'b000, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        // Idle after reset release: seeds held, no pulses.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_all("idle_hold", 32'hACE1_3579, 32'h5A5A_C3E7, 32'h1F2E_3D4C, 1'b0, 3'b000, 1'b0);
        end

        // Seed lfsr0 with 1 then advance twice.
        seed_we_i = 3'b001; seed_wdata_i = 32'h0000_0001;
        tick();
        idle();
        chk("seed0_val", lfsr0_o, 32'h0000_0001);
        chk("seed0_cntrst", {31'd0, cntrst_o}, 32'd1);
        shift_i = 3'b001;
        tick();
        chk_all("shift1", 32'h8020_0003, 32'h5A5A_C3E7, 32'h1F2E_3D4C, 1'b0, 3'b000, 1'b0);
        tick();
        idle();
        chk_all("shift2", 32'hC030_0002, 32'h5A5A_C3E7, 32'h1F2E_3D4C, 1'b0, 3'b000, 1'b0);

        // Zero seed into lfsr1 triggers recovery and a single alert pulse.
        seed_we_i = 3'b010; seed_wdata_i = 32'h0000_0000;
        tick();
        idle();
        chk_all("zero_seed1", 32'hC030_0002, 32'h5A5A_C3E7, 32'h1F2E_3D4C, 1'b0, 3'b010, 1'b1);
        tick();
        chk_all("zero_seed1_after", 32'hC030_0002, 32'h5A5A_C3E7, 32'h1F2E_3D4C, 1'b0, 3'b000, 1'b0);

        // Shift lfsr1 from its recovered seed.
        shift_i = 3'b010;
        tick();
        idle();
        chk("shift_lfsr1", lfsr1_o, 32'hAD0D_61F0);

        // Write and shift to lfsr2 in the same cycle: write wins, no cntrst.
        seed_we_i = 3'b100; shift_i = 3'b100; seed_wdata_i = 32'h1234_5678;
        tick();
        idle();
        chk_all("we_beats_shift", 32'hC030_0002, 32'hAD0D_61F0, 32'h1234_5678, 1'b0, 3'b000, 1'b0);

        // Independent strobes to all three LFSRs in one cycle.
        seed_we_i = 3'b011; shift_i = 3'b100; seed_wdata_i = 32'h0000_00FF;
        tick();
        idle();
        chk_all("multi_strobe", 32'h0000_00FF, 32'h0000_00FF, 32'h091A_2B3C, 1'b1, 3'b000, 1'b0);
        tick();
        chk("multi_strobe_cntrst_drop", {31'd0, cntrst_o}, 32'd0);

        // seed_we[0] with cpuctrl_we gives one pulse; cpuctrl alone two cycles later another.
        seed_we_i = 3'b001; seed_wdata_i = 32'hDEAD_BEEF; cpuctrl_we_i = 1'b1;
        tick();
        idle();
        chk("cntrst_n1", {31'd0, cntrst_o}, 32'd1);
        chk("cntrst_seed", lfsr0_o, 32'hDEAD_BEEF);
        tick();
        chk("cntrst_n2", {31'd0, cntrst_o}, 32'd0);
        cpuctrl_we_i = 1'b1;
        tick();
        idle();
        chk("cntrst_n3", {31'd0, cntrst_o}, 32'd1);
        tick();
        chk("cntrst_n4", {31'd0, cntrst_o}, 32'd0);

        // Back-to-back cpuctrl writes give a continuous high.
        cpuctrl_we_i = 1'b1;
        tick();
        chk("cntrst_b2b_1", {31'd0, cntrst_o}, 32'd1);
        tick();
        idle();
        chk("cntrst_b2b_2", {31'd0, cntrst_o}, 32'd1);
        tick();
        chk("cntrst_b2b_end", {31'd0, cntrst_o}, 32'd0);

        // Five shifts from seed 1, then async reset with pulses pending.
        seed_we_i = 3'b001; seed_wdata_i = 32'h0000_0001;
        tick();
        idle();
        shift_i = 3'b001;
        for (int i = 0; i < 5; i++) tick();
        idle();
        chk("five_shifts", lfsr0_o, 32'hD836_0002);
        seed_we_i = 3'b010; seed_wdata_i = 32'h0000_0000; cpuctrl_we_i = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 32'hACE1_3579, 32'h5A5A_C3E7, 32'h1F2E_3D4C, 1'b0, 3'b000, 1'b0);
        tick();
        idle();
        rst = 1'b0;
        tick();
        chk_all("post_rst1", 32'hACE1_3579, 32'h5A5A_C3E7, 32'h1F2E_3D4C, 1'b0, 3'b000, 1'b0);
        tick();
        chk_all("post_rst2", 32'hACE1_3579, 32'h5A5A_C3E7, 32'h1F2E_3D4C, 1'b0, 3'b000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
